// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: datapath width, ALU op codes, EX/MEM record types and the forwarding selector.
package ex_stage_pkg;
    localparam int WORD = 32;
    localparam int CNT_W = $clog2(WORD);
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLT = 4'd6,
        OP_SLL = 4'd7,
        OP_SRL = 4'd8,
        OP_SRA = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;
    typedef struct packed {
        logic mem_w;
        logic mem_r;
        logic wb_en;
        logic terminate;
    } ctrl_t;
    typedef struct packed {
        ctrl_t           ctrl;
        logic [4:0]      reg_dest;
        logic [WORD-1:0] alu_result;
        logic [WORD-1:0] st_data;
    } exmem_t;
    // The younger producer (EX/MEM) wins over MEM/WB; r0 is hardwired and never forwarded.
    function automatic logic [WORD-1:0] fwd_sel(
        input logic [4:0]      rs,
        input logic [WORD-1:0] val,
        input logic            ex_en,
        input logic [4:0]      ex_rd,
        input logic [WORD-1:0] ex_val,
        input logic            wb_en,
        input logic [4:0]      wb_rd,
        input logic [WORD-1:0] wb_val
    );
        return (rs != 5'd0 && ex_en && ex_rd == rs) ? ex_val :
               (rs != 5'd0 && wb_en && wb_rd == rs) ? wb_val : val;
    endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, forwarding sources, EX/MEM outputs and stall of the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;
    logic            mem_w_in, mem_r_in, wb_en_in, terminate_in;
    logic [3:0]      alu_op_in;
    logic [4:0]      reg_rs_in, reg_rt_in, reg_dest_in;
    logic [WORD-1:0] alu_1_data_in, alu_2_data_in, st_data_in;
    logic            fwd_2_en_in;
    logic            exmem_wb_en, memwb_wb_en;
    logic [4:0]      exmem_reg_dest, memwb_reg_dest;
    logic [WORD-1:0] exmem_alu_result, memwb_wb_data;
    logic            mem_w_out, mem_r_out, wb_en_out, terminate_out;
    logic [4:0]      reg_dest_out;
    logic [WORD-1:0] alu_result_out, st_data_out;
    logic            stall;
    modport master (
        output mem_w_in, mem_r_in, wb_en_in, terminate_in, alu_op_in,
        output reg_rs_in, reg_rt_in, reg_dest_in, alu_1_data_in, alu_2_data_in, st_data_in,
        output fwd_2_en_in, exmem_wb_en, memwb_wb_en, exmem_reg_dest, memwb_reg_dest,
        output exmem_alu_result, memwb_wb_data,
        input  mem_w_out, mem_r_out, wb_en_out, terminate_out, reg_dest_out,
        input  alu_result_out, st_data_out, stall
    );
    modport slave (
        input  mem_w_in, mem_r_in, wb_en_in, terminate_in, alu_op_in,
        input  reg_rs_in, reg_rt_in, reg_dest_in, alu_1_data_in, alu_2_data_in, st_data_in,
        input  fwd_2_en_in, exmem_wb_en, memwb_wb_en, exmem_reg_dest, memwb_reg_dest,
        input  exmem_alu_result, memwb_wb_data,
        output mem_w_out, mem_r_out, wb_en_out, terminate_out, reg_dest_out,
        output alu_result_out, st_data_out, stall
    );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per cycle, keeps the low WORD bits.
module seq_multiplier
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WORD-1:0] op_a,
    input  logic [WORD-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] product
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD - 1);
    logic            busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_next;
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
        end else if (busy_q) begin
            busy_d   = cnt_q != CNT_LAST;
            cnt_d    = cnt_q + 1'b1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_next;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
    // The last iteration's sum is presented directly so the result is ready in the done cycle.
    assign busy    = busy_q;
    assign done    = busy_q && cnt_q == CNT_LAST;
    assign product = acc_next;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, single-cycle ALU and a stalling multi-cycle MUL.
module ex_stage
    import ex_stage_pkg::*;
(
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e          state_q, state_d;
    exmem_t          out_q, out_d;
    ctrl_t           ctrl_in, mul_ctrl_q, mul_ctrl_d;
    logic [4:0]      mul_dest_q, mul_dest_d;
    logic [WORD-1:0] mul_st_q, mul_st_d;
    logic [WORD-1:0] op1, op2, st_fwd, alu_res, mul_prod;
    logic            stall, mul_start, mul_busy, mul_done;
    assign ctrl_in = '{mem_w: bus.mem_w_in, mem_r: bus.mem_r_in,
                       wb_en: bus.wb_en_in, terminate: bus.terminate_in};
    always_comb begin
        op1 = fwd_sel(bus.reg_rs_in, bus.alu_1_data_in,
                      bus.exmem_wb_en, bus.exmem_reg_dest, bus.exmem_alu_result,
                      bus.memwb_wb_en, bus.memwb_reg_dest, bus.memwb_wb_data);
        op2 = bus.fwd_2_en_in ?
              fwd_sel(bus.reg_rt_in, bus.alu_2_data_in,
                      bus.exmem_wb_en, bus.exmem_reg_dest, bus.exmem_alu_result,
                      bus.memwb_wb_en, bus.memwb_reg_dest, bus.memwb_wb_data) :
              bus.alu_2_data_in;
        st_fwd = fwd_sel(bus.reg_rt_in, bus.st_data_in,
                         bus.exmem_wb_en, bus.exmem_reg_dest, bus.exmem_alu_result,
                         bus.memwb_wb_en, bus.memwb_reg_dest, bus.memwb_wb_data);
    end
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(bus.alu_op_in))
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_NOR:  alu_res = ~(op1 | op2);
            OP_SLT:  alu_res = {{(WORD-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLL:  alu_res = op2 << op1[4:0];
            OP_SRL:  alu_res = op2 >> op1[4:0];
            OP_SRA:  alu_res = $signed(op2) >>> op1[4:0];
            default: alu_res = '0;
        endcase
    end
    always_comb begin
        state_d    = state_q;
        out_d      = '{ctrl: ctrl_in, reg_dest: bus.reg_dest_in, alu_result: alu_res, st_data: st_fwd};
        mul_ctrl_d = mul_ctrl_q;
        mul_dest_d = mul_dest_q;
        mul_st_d   = mul_st_q;
        mul_start  = 1'b0;
        stall      = 1'b0;
        if (state_q == IDLE) begin
            if (alu_op_e'(bus.alu_op_in) == OP_MUL) begin
                stall      = 1'b1;
                mul_start  = 1'b1;
                mul_ctrl_d = ctrl_in;
                mul_dest_d = bus.reg_dest_in;
                mul_st_d   = st_fwd;
                out_d      = '0;
                state_d    = BUSY;
            end
        end else begin
            out_d = '0;
            stall = mul_busy && !mul_done;
            if (mul_done) begin
                out_d   = '{ctrl: mul_ctrl_q, reg_dest: mul_dest_q, alu_result: mul_prod, st_data: mul_st_q};
                state_d = IDLE;
            end
        end
        if (rst) stall = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_q      <= '0;
            mul_ctrl_q <= '0;
            mul_dest_q <= '0;
            mul_st_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            mul_ctrl_q <= mul_ctrl_d;
            mul_dest_q <= mul_dest_d;
            mul_st_q   <= mul_st_d;
        end
    end
    seq_multiplier u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op_a    (op1),
        .op_b    (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
    assign bus.mem_w_out      = out_q.ctrl.mem_w;
    assign bus.mem_r_out      = out_q.ctrl.mem_r;
    assign bus.wb_en_out      = out_q.ctrl.wb_en;
    assign bus.terminate_out  = out_q.ctrl.terminate;
    assign bus.reg_dest_out   = out_q.reg_dest;
    assign bus.alu_result_out = out_q.alu_result;
    assign bus.st_data_out    = out_q.st_data;
    assign bus.stall          = stall;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table vectors, hand MUL/reset sequences and random ops against a behavioural model.
module tb_ex_stage;
    logic clk, rst;
    int n_vec = 0;
    int n_err = 0;
    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, sd;
        logic        f2;
        logic [3:0]  ctrl;
        logic        exen;
        logic [4:0]  exrd;
        logic [31:0] exv;
        logic        wben;
        logic [4:0]  wbrd;
        logic [31:0] wbv;
        logic [31:0] e_res, e_st;
    } vec_t;
    function automatic vec_t mk(input int op, input int rs, input int rt, input int rd,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                                input int f2, input int exen, input int exrd, input logic [31:0] exv,
                                input int wben, input int wbrd, input logic [31:0] wbv,
                                input logic [31:0] e_res, input logic [31:0] e_st);
        vec_t v;
        v.op = 4'(op); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.a = a; v.b = b; v.sd = sd; v.f2 = 1'(f2); v.ctrl = 4'b0010;
        v.exen = 1'(exen); v.exrd = 5'(exrd); v.exv = exv;
        v.wben = 1'(wben); v.wbrd = 5'(wbrd); v.wbv = wbv;
        v.e_res = e_res; v.e_st = e_st;
        return v;
    endfunction
    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] val, input vec_t t);
        if (r == 5'd0) return val;
        if (t.exen && t.exrd == r) return t.exv;
        if (t.wben && t.wbrd == r) return t.wbv;
        return val;
    endfunction
    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint unsigned p;
        int sx, sy;
        sx = x; sy = y;
        p = longint'(x) * longint'(y);
        case (op)
            0: return x + y;
            1: return x - y;
            2: return x & y;
            3: return x | y;
            4: return x ^ y;
            5: return ~(x | y);
            6: return (sx < sy) ? 32'd1 : 32'd0;
            7: return y << x[4:0];
            8: return y >> x[4:0];
            9: return 32'(sy >>> x[4:0]);
            10: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic [79:0] outs();
        return {7'b0, bus.mem_w_out, bus.mem_r_out, bus.wb_en_out, bus.terminate_out,
                bus.reg_dest_out, bus.alu_result_out, bus.st_data_out};
    endfunction
    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic apply(input vec_t v);
        bus.alu_op_in = v.op;
        bus.reg_rs_in = v.rs; bus.reg_rt_in = v.rt; bus.reg_dest_in = v.rd;
        bus.alu_1_data_in = v.a; bus.alu_2_data_in = v.b; bus.st_data_in = v.sd;
        bus.fwd_2_en_in = v.f2;
        {bus.mem_w_in, bus.mem_r_in, bus.wb_en_in, bus.terminate_in} = v.ctrl;
        bus.exmem_wb_en = v.exen; bus.exmem_reg_dest = v.exrd; bus.exmem_alu_result = v.exv;
        bus.memwb_wb_en = v.wben; bus.memwb_reg_dest = v.wbrd; bus.memwb_wb_data = v.wbv;
    endtask
    task automatic run_single(input vec_t v, input logic [31:0] e_res, input logic [31:0] e_st, input string name);
        apply(v);
        #1 chk({name, "_stall"}, 80'(bus.stall), 80'(0));
        @(posedge clk); #1;
        chk(name, outs(), {7'b0, v.ctrl, v.rd, e_res, e_st});
    endtask
    task automatic run_mul(input vec_t v, input bit scramble, input string name);
        logic [31:0] x, y, s, e;
        x = m_fwd(v.rs, v.a, v);
        y = v.f2 ? m_fwd(v.rt, v.b, v) : v.b;
        s = m_fwd(v.rt, v.sd, v);
        e = m_alu(4'd10, x, y);
        apply(v);
        for (int k = 0; k < 32; k++) begin
            if (scramble && k > 0) begin
                bus.exmem_wb_en = 1'b1; bus.exmem_reg_dest = v.rs; bus.exmem_alu_result = $urandom;
                bus.memwb_wb_en = 1'b1; bus.memwb_reg_dest = v.rt; bus.memwb_wb_data = $urandom;
            end
            #1 chk({name, "_busy_stall"}, 80'(bus.stall), 80'(1));
            @(posedge clk); #1;
            chk({name, "_bubble"}, outs(), 80'(0));
        end
        #1 chk({name, "_last_stall"}, 80'(bus.stall), 80'(0));
        @(posedge clk); #1;
        chk({name, "_result"}, outs(), {7'b0, v.ctrl, v.rd, e, s});
    endtask
    vec_t tbl[13];
    vec_t v;
    initial begin
        tbl[0]  = mk(0, 1, 2, 3, 5, 7, 0, 1, 0, 0, 0, 0, 0, 0, 12, 0);
        tbl[1]  = mk(0, 3, 4, 6, 55, 1, 0, 0, 1, 3, 100, 1, 3, 200, 101, 0);
        tbl[2]  = mk(0, 0, 0, 6, 4, 4, 6, 0, 1, 0, 9, 0, 0, 0, 8, 6);
        tbl[3]  = mk(0, 1, 5, 7, 10, 20, 'h33, 0, 1, 5, 'h77, 0, 0, 0, 30, 'h77);
        tbl[4]  = mk(1, 1, 2, 3, 3, 5, 0, 1, 0, 0, 0, 0, 0, 0, 'hFFFF_FFFE, 0);
        tbl[5]  = mk(6, 1, 2, 3, 'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(9, 1, 2, 3, 4, 'h8000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 'hF800_0000, 0);
        tbl[7]  = mk(3, 1, 7, 3, 1, 'hFF, 'h99, 1, 0, 0, 0, 1, 7, 'h10, 'h11, 'h10);
        tbl[8]  = mk(15, 1, 2, 3, 9, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(5, 1, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'hFFFF_FFFF, 0);
        tbl[10] = mk(8, 1, 2, 3, 4, 'h8000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 'h0800_0000, 0);
        tbl[11] = mk(2, 2, 3, 4, 'hF0F0, 'hFF00, 0, 1, 1, 3, 'h0FF0, 1, 2, 'hFFFF, 'h0FF0, 'h0FF0);
        tbl[12] = mk(7, 1, 2, 3, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 'h100, 0);
        rst = 1'b1;
        apply(mk(0, 1, 2, 3, 5, 7, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("reset_stall", 80'(bus.stall), 80'(0));
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", outs(), 80'(0));
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tbl[i].ctrl = 4'(i + 5);
            run_single(tbl[i], tbl[i].e_res, tbl[i].e_st, $sformatf("vec%0d", i));
        end
        v = mk(10, 1, 2, 9, 'hFFFF_FFFF, 3, 'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.ctrl = 4'b0011;
        run_mul(v, 1'b0, "mul_max_x3");
        chk("mul_max_x3_value", 80'(bus.alu_result_out), 80'(32'hFFFF_FFFD));
        v = mk(10, 1, 2, 4, 0, 6, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0);
        v.ctrl = 4'b1000;
        run_mul(v, 1'b1, "mul_back2back");
        chk("mul_back2back_value", 80'(bus.alu_result_out), 80'(42));
        v = mk(10, 1, 2, 4, 123, 456, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.ctrl = 4'b1111;
        apply(v);
        for (int k = 0; k < 10; k++) begin
            #1 chk("rst_mid_busy_stall", 80'(bus.stall), 80'(1));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1 chk("rst_mid_stall", 80'(bus.stall), 80'(0));
        @(posedge clk); #1;
        chk("rst_mid_outputs", outs(), 80'(0));
        rst = 1'b0;
        v = mk(0, 1, 2, 3, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_single(v, 5, 0, "add_after_rst");
        v = mk(10, 1, 2, 3, 'h1_0000, 'h1_0001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_mul(v, 1'b0, "mul_after_rst");
        for (int i = 0; i < 150; i++) begin
            logic [31:0] x, y;
            v.op = ($urandom_range(0, 99) < 15) ? 4'd10 : 4'($urandom_range(0, 15));
            v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3)); v.rd = 5'($urandom);
            v.a = $urandom; v.b = $urandom; v.sd = $urandom;
            if ($urandom_range(0, 3) == 0) v.a = 32'($urandom_range(0, 40));
            v.f2 = 1'($urandom); v.ctrl = 4'($urandom);
            v.exen = 1'($urandom); v.exrd = 5'($urandom_range(0, 3)); v.exv = $urandom;
            v.wben = 1'($urandom); v.wbrd = 5'($urandom_range(0, 3)); v.wbv = $urandom;
            x = m_fwd(v.rs, v.a, v);
            y = v.f2 ? m_fwd(v.rt, v.b, v) : v.b;
            if (v.op == 4'd10) run_mul(v, 1'b1, $sformatf("rnd%0d_mul", i));
            else run_single(v, m_alu(v.op, x, y), m_fwd(v.rt, v.sd, v), $sformatf("rnd%0d_op%0d", i, v.op));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: WORD, `WORD from constants.v (32), datapath width.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_w_in, mem_r_in, wb_en_in, terminate_in  in  1 each  control bits from ID/EX register.
REQ-005 alu_op_in  in  4  ALU operation code.
REQ-006 reg_rs_in, reg_rt_in, reg_dest_in  in  5 each  source/destination register numbers.
REQ-007 alu_1_data_in, alu_2_data_in, st_data_in  in  WORD each  operands and store data from ID/EX.
REQ-008 fwd_2_en_in  in  1  operand 2 came from register rt (0 = immediate, never forwarded).
REQ-009 exmem_wb_en, memwb_wb_en  in  1 each  write-enable of older instructions.
REQ-010 exmem_reg_dest, memwb_reg_dest  in  5 each  their destination registers.
REQ-011 exmem_alu_result, memwb_wb_data  in  WORD each  their result values.
REQ-012 mem_w_out, mem_r_out, wb_en_out, terminate_out  out  1 each  registered EX/MEM control.
REQ-013 reg_dest_out  out  5; alu_result_out, st_data_out  out  WORD  registered EX/MEM data.
REQ-014 stall  out  1  combinational; high = ID/EX and earlier stages hold.

Function
REQ-015 Forwarding SHALL apply to operand 1 on reg_rs_in, to operand 2 on reg_rt_in only when fwd_2_en_in=1, and to store data on reg_rt_in.
REQ-016 Source SHALL be exmem_alu_result if exmem_wb_en and exmem_reg_dest matches, else memwb_wb_data if memwb_wb_en and memwb_reg_dest matches, else the ID/EX value; register 0 SHALL never be forwarded.
REQ-017 Load-use hazards SHALL be resolved upstream; this block SHALL NOT detect them.
REQ-018 Op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6 (signed, result 0/1), SLL 7, SRL 8, SRA 9 (operand 2 shifted by operand 1[4:0]), MUL 10 (low WORD bits of unsigned product); undefined codes SHALL produce 0.
REQ-019 ADD/SUB SHALL wrap modulo 2^WORD; no overflow flag.
REQ-020 Non-MUL ops: single cycle; at each posedge all outputs load forwarded/computed values and input control bits; stall=0.
REQ-021 FSM states IDLE, BUSY; reset state IDLE.
REQ-022 IDLE with alu_op_in=MUL: stall=1; forwarded operands, store data, reg_dest and control latched; counter cleared; go BUSY; outputs load a bubble (all control bits 0, data 0).
REQ-023 BUSY: one shift-add iteration per cycle; outputs hold bubble; stall=1 while counter < WORD-1.
REQ-024 BUSY with counter = WORD-1: stall=0; final iteration completes; outputs load MUL result with latched control; go IDLE.
REQ-025 Hence stall is high exactly WORD cycles per MUL and the result reaches EX/MEM WORD+1 edges after MUL first enters.
REQ-026 Operands SHALL be those forwarded in the IDLE start cycle; forwarding inputs are ignored during BUSY.
REQ-027 Back-to-back MULs: second MUL seen in IDLE next cycle SHALL start normally.
REQ-028 terminate_in on a MUL SHALL appear on terminate_out with the result, not earlier.

Reset
REQ-029 rst=1 at posedge: every output register 0, state IDLE, counter 0, multiplier registers 0; an in-progress MUL is discarded.
REQ-030 stall SHALL be 0 while rst=1.

Structure
REQ-031 WORD and the ALU op codes SHALL live in constants.v; FSM state codes are local.
REQ-032 One sub-module seq_multiplier (start, operands, busy, done, product) SHALL hold the iterative multiplier; forwarding and ALU stay in ex_stage.

Verification
REQ-033 ADD 5+7, no forwarding -> alu_result_out=12 one edge later, stall=0.
REQ-034 rs=3, exmem dest=3 value 100, memwb dest=3 value 200, ADD operand 2=1 -> 101 (EX/MEM priority).
REQ-035 rs=0 with exmem dest=0 wb_en=1 value 9, alu_1_data_in=4, ADD 4 -> 8 (no forward of r0).
REQ-036 fwd_2_en_in=0, rt=5, exmem dest=5 -> immediate used; st_data_out still forwarded.
REQ-037 MUL 0xFFFFFFFF*3 -> stall high 32 cycles, bubbles meanwhile, result 0xFFFFFFFD with wb_en_out=1 at edge 33.
REQ-038 rst asserted mid-MUL (cycle 10) -> all outputs 0, stall 0 next cycle; a following ADD completes in one cycle.
